// File: rtl/buzzer_seq_ctrl.sv
// Note sequencer for the buzzer: fetches packed note words, plays tone/rest for beats*BEAT_DIV cycles.
// Optional macro BUZZ_LOOP_EN adds a 'loop' input that restarts the song at the end marker.
module buzzer_seq_ctrl #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned BEAT_W        = 4,
    parameter int unsigned TONE_PRESCALE = 16,
    parameter int unsigned BEAT_DIV      = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              pause,
    input  logic              abort,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              buzz_out,
    output logic              busy,
    output logic              done
`ifdef BUZZ_LOOP_EN
    ,
    input  logic              loop
`endif
);

    localparam int unsigned TONE_W = DATA_W - BEAT_W;
    localparam int unsigned TCNT_W = TONE_W + $clog2(TONE_PRESCALE + 1);
    localparam int unsigned BP_W   = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY, PAUSED} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q, first_q;
    logic [TONE_W-1:0] tone_q;
    logic [BEAT_W-1:0] beats_q;
    logic [TCNT_W-1:0] tone_cnt_q, tone_cnt_d, tone_lim;
    logic [BP_W-1:0]   beat_pre_q, beat_pre_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              phase_q, phase_d;
    logic              mem_req_q, buzz_q, busy_q, done_q;
    logic              tone_tc, beat_tc, note_end, loop_en;
    logic [TONE_W-1:0] word_tone;
    logic [BEAT_W-1:0] word_beats;

`ifdef BUZZ_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    assign word_tone  = mem_rdata[TONE_W-1:0];
    assign word_beats = mem_rdata[DATA_W-1 -: BEAT_W];

    // A rest (tone 0) never reaches terminal count, so the drive stays low.
    assign tone_lim = TCNT_W'(tone_q) * TCNT_W'(TONE_PRESCALE);
    assign tone_tc  = (tone_q != '0) && (tone_cnt_q == tone_lim - TCNT_W'(1));
    assign beat_tc  = (beat_pre_q == BP_W'(BEAT_DIV - 1));
    assign note_end = beat_tc && (beat_cnt_q == beats_q - BEAT_W'(1));

    always_comb begin
        tone_cnt_d = tone_tc ? '0 : tone_cnt_q + TCNT_W'(1);
        phase_d    = phase_q ^ tone_tc;
        beat_pre_d = beat_tc ? '0 : beat_pre_q + BP_W'(1);
        beat_cnt_d = beat_tc ? beat_cnt_q + BEAT_W'(1) : beat_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            first_q    <= '0;
            tone_q     <= '0;
            beats_q    <= '0;
            tone_cnt_q <= '0;
            beat_pre_q <= '0;
            beat_cnt_q <= '0;
            phase_q    <= 1'b0;
            mem_req_q  <= 1'b0;
            buzz_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && state_q != IDLE) begin
                state_q   <= IDLE;
                mem_req_q <= 1'b0;
                buzz_q    <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        addr_q    <= start_addr;
                        first_q   <= start_addr;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= FETCH;
                    end
                    FETCH: if (mem_ack) begin
                        if (mem_rdata == '0) begin
                            done_q <= 1'b1;
                            // Looping an empty song would spin forever; treat it as a plain end.
                            if (loop_en && addr_q != first_q) begin
                                addr_q <= first_q;
                            end else begin
                                mem_req_q <= 1'b0;
                                busy_q    <= 1'b0;
                                state_q   <= IDLE;
                            end
                        end else begin
                            tone_q     <= word_tone;
                            beats_q    <= (word_beats == '0) ? BEAT_W'(1) : word_beats;
                            tone_cnt_q <= '0;
                            beat_pre_q <= '0;
                            beat_cnt_q <= '0;
                            phase_q    <= 1'b0;
                            buzz_q     <= 1'b0;
                            mem_req_q  <= 1'b0;
                            state_q    <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (note_end) begin
                            addr_q    <= addr_q + ADDR_W'(1);
                            buzz_q    <= 1'b0;
                            mem_req_q <= 1'b1;
                            state_q   <= FETCH;
                        end else begin
                            tone_cnt_q <= tone_cnt_d;
                            beat_pre_q <= beat_pre_d;
                            beat_cnt_q <= beat_cnt_d;
                            phase_q    <= phase_d;
                            if (pause) begin
                                buzz_q  <= 1'b0;
                                state_q <= PAUSED;
                            end else begin
                                buzz_q <= phase_d;
                            end
                        end
                    end
                    PAUSED: if (!pause) begin
                        // Resume with the phase held across the pause.
                        buzz_q  <= phase_q;
                        state_q <= PLAY;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = addr_q;
    assign buzz_out = buzz_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
